// File: rtl/link_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// link_arbiter_if: requester-side and link-side signals of link_arbiter
// Revision 1.0
// ------------------------------------------------------------------------
interface link_arbiter_if;
  logic [3:0]  m_req;
  logic [31:0] m_data;
  logic [3:0]  m_ack;
  logic        s_req;
  logic [7:0]  s_data;
  logic        s_ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic [7:0]  xfer_cnt;
  logic        timeout_err;
  logic        err_clr;

  // The arbiter itself sits on the slave modport; the environment drives master.
  modport slave (
    input  m_req, m_data, s_ack, err_clr,
    output m_ack, s_req, s_data, grant_id, busy, xfer_cnt, timeout_err
  );

  modport master (
    output m_req, m_data, s_ack, err_clr,
    input  m_ack, s_req, s_data, grant_id, busy, xfer_cnt, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/link_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// link_arbiter: 4-way round-robin arbiter onto one 4-phase link slave
// Revision 1.0
// ------------------------------------------------------------------------
module link_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  wire logic     clk,
  input  wire logic     rst,
  link_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [1:0] ptr, ptr_nx;
  logic [1:0] grant, grant_nx;
  logic [7:0] timer, timer_nx;
  logic       aborted, aborted_nx;
  logic [3:0] ack, ack_nx;
  logic       sreq, sreq_nx;
  logic [7:0] sdata, sdata_nx;
  logic       busy_q, busy_nx;
  logic [7:0] cnt, cnt_nx;
  logic       err, err_nx;
  logic       set_err;

  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;

  // Round-robin scan starting at ptr; first set request wins.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && bus.m_req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    grant_nx   = grant;
    timer_nx   = timer;
    aborted_nx = aborted;
    ack_nx     = ack;
    sreq_nx    = sreq;
    sdata_nx   = sdata;
    cnt_nx     = cnt;
    set_err    = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          grant_nx   = pick;
          sdata_nx   = bus.m_data[{pick, 3'b000} +: 8];
          sreq_nx    = 1'b1;
          timer_nx   = 8'd0;
          aborted_nx = 1'b0;
          state_nx   = REQ;
        end else begin
          sreq_nx = 1'b0;
          ack_nx  = 4'b0000;
        end
      end
      REQ: begin
        // An acknowledge sampled on the final timer cycle still wins.
        if (bus.s_ack) begin
          ack_nx   = 4'b0001 << grant;
          state_nx = HOLD;
        end else if (timer == TIMER_LAST) begin
          sreq_nx    = 1'b0;
          set_err    = 1'b1;
          aborted_nx = 1'b1;
          state_nx   = DROP;
        end else begin
          timer_nx = timer + 8'd1;
        end
      end
      HOLD: begin
        if (!bus.m_req[grant]) begin
          ack_nx   = 4'b0000;
          sreq_nx  = 1'b0;
          state_nx = DROP;
        end
      end
      DROP: begin
        if (!bus.s_ack) begin
          ptr_nx   = grant + 2'd1;
          state_nx = IDLE;
          if (!aborted) begin
            cnt_nx = cnt + 8'd1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    err_nx = err;
    if (set_err) begin
      err_nx = 1'b1;
    end else if (bus.err_clr) begin
      err_nx = 1'b0;
    end

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      grant   <= 2'd0;
      timer   <= 8'd0;
      aborted <= 1'b0;
      ack     <= 4'b0000;
      sreq    <= 1'b0;
      sdata   <= 8'd0;
      busy_q  <= 1'b0;
      cnt     <= 8'd0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      grant   <= grant_nx;
      timer   <= timer_nx;
      aborted <= aborted_nx;
      ack     <= ack_nx;
      sreq    <= sreq_nx;
      sdata   <= sdata_nx;
      busy_q  <= busy_nx;
      cnt     <= cnt_nx;
      err     <= err_nx;
    end
  end

  assign bus.m_ack       = ack;
  assign bus.s_req       = sreq;
  assign bus.s_data      = sdata;
  assign bus.grant_id    = grant;
  assign bus.busy        = busy_q;
  assign bus.xfer_cnt    = cnt;
  assign bus.timeout_err = err;

endmodule
`default_nettype wire
